// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide engine: FSM states, op encodings
// and a state-decode helper used by muldiv_unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  function automatic logic is_busy_state(input state_e s);
    return (s == CALC) || (s == FIX);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Single iteration of the muldiv datapath: one shift-add step for multiply
// (LSB first) or one restoring trial-subtract step for divide (MSB first).
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH:0]     rem,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [WIDTH:0]     rem_nx
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] diff_s;
  logic             qbit_s;
  logic             unused_rem_msb_s;

  // The remainder never exceeds the divisor, so its top bit only serves the trial subtract width.
  assign unused_rem_msb_s = rem[WIDTH];

  // One datapath step selected by the latched operation
  always_comb begin
    sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted_s = {rem[WIDTH-1:0], acc[WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, opnd};
    qbit_s    = 1'b0;
    acc_nx    = acc;
    rem_nx    = rem;
    if (op == OP_MULT) begin
      acc_nx = {sum_s, acc[WIDTH-1:1]};
      rem_nx = rem;
    end else begin
      if (diff_s[WIDTH+1]) begin
        qbit_s = 1'b0;
        rem_nx = shifted_s;
      end else begin
        qbit_s = 1'b1;
        rem_nx = diff_s[WIDTH:0];
      end
      acc_nx = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], qbit_s};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine with start/busy/done handshake and HI/LO results.
// Signed operation is available when MULDIV_SIGNED_EN is defined; otherwise all ops are unsigned.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_r, state_nx_s;
  logic                 busy_r, done_r, busy_nx_s, done_nx_s;
  logic                 div_zero_r, op_r, neg_a_r, neg_b_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [WIDTH-1:0]     opnd_r, hi_r, lo_r;
  logic [2*WIDTH-1:0]   acc_r, acc_nx_s;
  logic [WIDTH:0]       rem_r, rem_nx_s;
  logic                 accept_s, dz_s, last_s, neg_a_s, neg_b_s;
  logic [WIDTH-1:0]     abs_a_s, abs_b_s, quo_fix_s, rem_fix_s;
  logic [2*WIDTH-1:0]   prod_fix_s;

  assign accept_s = (state_r == IDLE) && start;
  assign dz_s     = (op == OP_DIV) && (b_in == {WIDTH{1'b0}});
  assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
  assign neg_a_s    = sgn & a_in[WIDTH-1];
  assign neg_b_s    = sgn & b_in[WIDTH-1];
  assign abs_a_s    = neg_a_s ? -a_in : a_in;
  assign abs_b_s    = neg_b_s ? -b_in : b_in;
  assign prod_fix_s = (neg_a_r ^ neg_b_r) ? -acc_r : acc_r;
  assign quo_fix_s  = (neg_a_r ^ neg_b_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
  // Remainder follows the dividend's sign
  assign rem_fix_s  = neg_a_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
`else
  logic unused_sign_s;
  assign neg_a_s       = 1'b0;
  assign neg_b_s       = 1'b0;
  assign abs_a_s       = a_in;
  assign abs_b_s       = b_in;
  assign prod_fix_s    = acc_r;
  assign quo_fix_s     = acc_r[WIDTH-1:0];
  assign rem_fix_s     = rem_r[WIDTH-1:0];
  assign unused_sign_s = sgn ^ neg_a_r ^ neg_b_r;
`endif

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .op     (op_r),
    .acc    (acc_r),
    .rem    (rem_r),
    .opnd   (opnd_r),
    .acc_nx (acc_nx_s),
    .rem_nx (rem_nx_s)
  );

  // State register and registered handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Next-state logic; a start seen outside IDLE is dropped
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = start ? (dz_s ? DONE : CALC) : IDLE;
      CALC:    state_nx_s = last_s ? FIX : CALC;
      FIX:     state_nx_s = DONE;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Flag values for the upcoming state, registered above
  always_comb begin
    busy_nx_s = is_busy_state(state_nx_s);
    done_nx_s = (state_nx_s == DONE);
  end

  // Operand latch, iteration registers and result write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r       <= OP_MULT;
      neg_a_r    <= 1'b0;
      neg_b_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      rem_r      <= {(WIDTH+1){1'b0}};
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      op_r       <= op;
      neg_a_r    <= neg_a_s;
      neg_b_r    <= neg_b_s;
      cnt_r      <= {CNT_W{1'b0}};
      opnd_r     <= (op == OP_DIV) ? abs_b_s : abs_a_s;
      acc_r      <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? abs_a_s : abs_b_s)};
      rem_r      <= {(WIDTH+1){1'b0}};
      div_zero_r <= dz_s;
    end else if (state_r == CALC) begin
      acc_r <= acc_nx_s;
      rem_r <= rem_nx_s;
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (state_r == FIX) begin
      if (op_r == OP_MULT) begin
        hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
        lo_r <= prod_fix_s[WIDTH-1:0];
      end else begin
        hi_r <= rem_fix_s;
        lo_r <= quo_fix_s;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule
